wr_resp_scheduler: RTL and testbench



---
 rtl/wr_resp_scheduler.sv | 108 ++++++++++
 tb/tb_wr_resp_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_resp_scheduler.sv
// Write-response scheduler: routes producer responses to per-direction
// round-robin arbitrated FIFOs selected by txnid[1:0].
package wr_resp_pkg;
  typedef struct packed {
    logic [7:0] txnid;
    logic [7:0] sideband;
  } wr_resp_pld_t;
endpackage

module wr_resp_scheduler
  import wr_resp_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int N_DIR = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_vld,
  input  wr_resp_pld_t [N_SRC-1:0] src_pld,
  output logic [N_SRC-1:0]         src_rdy,
  output logic [N_DIR-1:0]         v_wresp_vld,
  output wr_resp_pld_t [N_DIR-1:0] v_wresp_pld,
  input  logic [N_DIR-1:0]         v_wresp_rdy,
  output logic                     idle
);

  localparam int SW = $clog2(N_SRC);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt     [N_DIR];
  logic [AW-1:0] wr_ptr  [N_DIR];
  logic [AW-1:0] rd_ptr  [N_DIR];
  logic [SW-1:0] rr      [N_DIR];
  logic [SW-1:0] gnt_idx [N_DIR];
  wr_resp_pld_t  mem     [N_DIR][DEPTH];

  logic [N_DIR-1:0] gnt;
  logic [N_DIR-1:0] pop;
  logic [SW-1:0]    idx;
  logic             empty_all;

  // A full FIFO takes no grant even if it pops this cycle.
  always_comb begin
    gnt     = '0;
    src_rdy = '0;
    idx     = '0;
    for (int d = 0; d < N_DIR; d++) begin
      gnt_idx[d] = '0;
      for (int i = 0; i < N_SRC; i++) begin
        idx = SW'(rr[d] + SW'(i));
        if (!rst && !gnt[d] &&
            cnt[d] < CW'(DEPTH) &&
            src_vld[idx] &&
            src_pld[idx].txnid[1:0] == 2'(d)) begin
          gnt[d]     = 1'b1;
          gnt_idx[d] = idx;
        end
      end
      if (gnt[d]) src_rdy[gnt_idx[d]] = 1'b1;
    end
  end

  always_comb begin
    empty_all = 1'b1;
    for (int d = 0; d < N_DIR; d++) begin
      v_wresp_vld[d] = (cnt[d] != '0);
      v_wresp_pld[d] = v_wresp_vld[d] ?
                       mem[d][rd_ptr[d]] : '0;
      pop[d]         = v_wresp_vld[d] && v_wresp_rdy[d];
      if (cnt[d] != '0) empty_all = 1'b0;
    end
    idle = empty_all && (src_vld == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < N_DIR; d++) begin
        cnt[d]    <= '0;
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
        rr[d]     <= '0;
      end
    end else begin
      for (int d = 0; d < N_DIR; d++) begin
        if (gnt[d]) begin
          wr_ptr[d] <= wr_ptr[d] + AW'(1);
          rr[d]     <= gnt_idx[d] + SW'(1);
        end
        if (pop[d]) rd_ptr[d] <= rd_ptr[d] + AW'(1);
        unique case ({gnt[d], pop[d]})
          2'b10:   cnt[d] <= cnt[d] + CW'(1);
          2'b01:   cnt[d] <= cnt[d] - CW'(1);
          default: cnt[d] <= cnt[d];
        endcase
      end
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    for (int d = 0; d < N_DIR; d++) begin
      if (gnt[d]) mem[d][wr_ptr[d]] <= src_pld[gnt_idx[d]];
    end
  end

endmodule

// File: tb/tb_wr_resp_scheduler.sv
// Directed bench for wr_resp_scheduler: routing, RR, full/backpressure,
// direction independence and asynchronous reset.
module tb_wr_resp_scheduler;
  import wr_resp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           src_vld;
  wr_resp_pld_t [3:0]   src_pld;
  logic [3:0]           src_rdy;
  logic [3:0]           v_wresp_vld;
  wr_resp_pld_t [3:0]   v_wresp_pld;
  logic [3:0]           v_wresp_rdy;
  logic                 idle;

  int n_vec = 0;
  int n_err = 0;

  wr_resp_scheduler #(.N_SRC(4), .N_DIR(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_vld     (src_vld),
    .src_pld     (src_pld),
    .src_rdy     (src_rdy),
    .v_wresp_vld (v_wresp_vld),
    .v_wresp_pld (v_wresp_pld),
    .v_wresp_rdy (v_wresp_rdy),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v,
                         input logic [7:0] t);
    src_vld[s]          = v;
    src_pld[s].txnid    = t;
    src_pld[s].sideband = ~t;
  endtask

  initial begin
    rst         = 1'b1;
    src_vld     = '0;
    src_pld     = '0;
    v_wresp_rdy = 4'hF;
    #12;
    chk("rst_vld", 32'(v_wresp_vld), 0);
    chk("rst_pld", 32'(v_wresp_pld), 0);
    chk("rst_rdy", 32'(src_rdy), 0);
    chk("rst_idle", 32'(idle), 1);
    @(negedge clk);
    rst = 1'b0;

    // single response, dir 1
    cyc();
    set_src(2, 1'b1, 8'h1D);
    #1;
    chk("single_rdy", 32'(src_rdy), 32'h4);
    chk("single_novld", 32'(v_wresp_vld), 0);
    chk("single_busy", 32'(idle), 0);
    cyc();
    set_src(2, 1'b0, 8'h00);
    #1;
    chk("single_vld", 32'(v_wresp_vld), 32'h2);
    chk("single_txn", 32'(v_wresp_pld[1].txnid), 32'h1D);
    chk("single_sb", 32'(v_wresp_pld[1].sideband), 32'hE2);
    chk("single_idle0", 32'(idle), 0);
    cyc();
    chk("single_idle1", 32'(idle), 1);
    chk("single_empty", 32'(v_wresp_vld), 0);

    // round robin, all sources to dir 0
    cyc();
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, 8'(s * 16));
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk("rr_gnt", 32'(src_rdy), 32'(1 << (k % 4)));
      if (k > 0)
        chk("rr_out", 32'(v_wresp_pld[0].txnid),
            32'(((k - 1) % 4) * 16));
    end
    cyc();
    src_vld = '0;
    #1;
    chk("rr_last", 32'(v_wresp_pld[0].txnid), 32'h30);
    cyc();
    chk("rr_drain", 32'(v_wresp_vld), 0);

    // full backpressure on dir 3 from src0
    v_wresp_rdy[3] = 1'b0;
    set_src(0, 1'b1, 8'h03);
    #1;
    chk("full_a0", 32'(src_rdy), 1);
    cyc(); set_src(0, 1'b1, 8'h07); #1;
    chk("full_a1", 32'(src_rdy), 1);
    chk("full_head", 32'(v_wresp_pld[3].txnid), 32'h03);
    cyc(); set_src(0, 1'b1, 8'h0B); #1;
    chk("full_a2", 32'(src_rdy), 1);
    cyc(); set_src(0, 1'b1, 8'h0F); #1;
    chk("full_a3", 32'(src_rdy), 1);
    cyc(); set_src(0, 1'b1, 8'h13); #1;
    chk("full_blk0", 32'(src_rdy), 0);
    chk("full_stable", 32'(v_wresp_pld[3].txnid), 32'h03);
    cyc();
    chk("full_blk1", 32'(src_rdy), 0);
    chk("full_vld", 32'(v_wresp_vld), 32'h8);
    cyc(); v_wresp_rdy[3] = 1'b1; #1;
    chk("fullpop_blk", 32'(src_rdy), 0);
    chk("fullpop_out", 32'(v_wresp_pld[3].txnid), 32'h03);
    cyc(); v_wresp_rdy[3] = 1'b0; #1;
    chk("fullpop_acc", 32'(src_rdy), 1);
    chk("fullpop_head", 32'(v_wresp_pld[3].txnid), 32'h07);
    cyc(); set_src(0, 1'b1, 8'h17); #1;
    chk("refull_blk", 32'(src_rdy), 0);
    cyc(); v_wresp_rdy[3] = 1'b1; #1;
    chk("drain_blk", 32'(src_rdy), 0);
    chk("drain_07", 32'(v_wresp_pld[3].txnid), 32'h07);
    cyc();
    chk("drain_acc", 32'(src_rdy), 1);
    chk("drain_0b", 32'(v_wresp_pld[3].txnid), 32'h0B);
    cyc(); set_src(0, 1'b0, 8'h00); #1;
    chk("drain_0f", 32'(v_wresp_pld[3].txnid), 32'h0F);
    cyc();
    chk("drain_13", 32'(v_wresp_pld[3].txnid), 32'h13);
    cyc();
    chk("drain_17", 32'(v_wresp_pld[3].txnid), 32'h17);
    cyc();
    chk("drain_done", 32'(v_wresp_vld), 0);
    chk("drain_idle", 32'(idle), 1);

    // dir 0 stalled and full, src1 streams to dir 2
    v_wresp_rdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      set_src(2, 1'b1, 8'(8'h40 + 4 * k));
      #1;
      chk("ind_fill", 32'(src_rdy), 32'h4);
    end
    cyc();
    set_src(2, 1'b1, 8'h50);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      set_src(1, 1'b1, 8'(8'h02 + 4 * k));
      #1;
      chk("ind_gnt", 32'(src_rdy), 32'h2);
      chk("ind_d0full", 32'(v_wresp_pld[0].txnid), 32'h40);
      if (k > 0)
        chk("ind_stream", 32'(v_wresp_pld[2].txnid),
            32'(8'h02 + 4 * (k - 1)));
    end
    cyc();
    set_src(1, 1'b0, 8'h00);
    set_src(2, 1'b0, 8'h00);
    #1;
    chk("ind_last", 32'(v_wresp_pld[2].txnid), 32'h0E);

    // reset with 3 entries queued on dir 1
    v_wresp_rdy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      set_src(1, 1'b1, 8'(8'h01 + 4 * k));
      #1;
      chk("rst_fill", 32'(src_rdy), 32'h2);
    end
    cyc();
    set_src(1, 1'b0, 8'h00);
    #1;
    chk("rst_q", 32'(v_wresp_pld[1].txnid), 32'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(v_wresp_vld), 0);
    chk("arst_pld", 32'(v_wresp_pld), 0);
    chk("arst_idle", 32'(idle), 1);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    v_wresp_rdy = 4'hF;
    set_src(1, 1'b1, 8'h11);
    set_src(3, 1'b1, 8'h31);
    #1;
    chk("arst_rr", 32'(src_rdy), 32'h2);
    cyc();
    src_vld = '0;
    #1;
    chk("arst_push_vld", 32'(v_wresp_vld), 32'h2);
    chk("arst_push_txn", 32'(v_wresp_pld[1].txnid), 32'h11);
    chk("arst_push_sb", 32'(v_wresp_pld[1].sideband), 32'hEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
